// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle ripple adder, CHUNK bits per clock, start/busy/done handshake.
// Optional subtract port enabled by CHUNK_ADDER_SUB_EN.
module chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] op_a, op_b, b_in;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_c, b_c, s;
    logic             carry, c, c_in, last, accept;

`ifdef CHUNK_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign a_c    = op_a[idx*CHUNK +: CHUNK];
    assign b_c    = op_b[idx*CHUNK +: CHUNK];
    assign {c, s} = {1'b0, a_c} + {1'b0, b_c} + (CHUNK+1)'(carry);
    assign last   = idx == IW'(N - 1);
    assign busy   = state == RUN;
    assign done   = state == DONE;
    assign accept = start && state != RUN;

    always_comb begin
        state_n = state;
        state_n = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_a  <= a;
                op_b  <= b_in;
                carry <= c_in;
                idx   <= '0;
                sum   <= '0;
                cout  <= 1'b0;
                ovf   <= 1'b0;
            end else if (busy) begin
                sum[idx*CHUNK +: CHUNK] <= s;
                carry <= c;
                if (last) begin
                    // carry into the MSB is recovered from the MSB sum bit
                    cout <= c;
                    ovf  <= a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ s[CHUNK-1] ^ c;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_chunk_adder.sv
// tb_chunk_adder: scoreboard bench for chunk_adder with directed vectors.
module tb_chunk_adder;
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, start, cin, sub;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;
    res_t        q[$];
    int          total = 0;
    int          bad = 0;

    chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef CHUNK_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        res_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got sum=%h cout=%b ovf=%b with no result pending", sum, cout, ovf);
                end else begin
                    e = q.pop_front();
                    if ({sum, cout, ovf} !== e) begin
                        bad++;
                        $display("FAIL result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e.s, e.c, e.o);
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic isub,
                         input bit push, input logic [15:0] es, input logic ec, input logic eo);
        a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
        if (push) q.push_back('{es, ec, eo});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_op(input int exp_busy);
        int nb = 0;
        int guard = 0;
        @(negedge clk);
        while (!done && guard < 20) begin
            if (busy) nb++;
            guard++;
            @(negedge clk);
        end
        check("done_seen", 32'(done), 1);
        check("busy_cycles", nb, exp_busy);
        check("busy_in_done", 32'(busy), 0);
    endtask

    initial begin
        int err;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        err = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) err++;
        end
        check("idle_quiet", err, 0);
        // back-to-back: each new start lands in the previous done cycle
        issue(16'h00FF, 16'h0001, 0, 0, 1, 16'h0100, 0, 0);
        finish_op(4);
        issue(16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 1, 0);
        finish_op(4);
        issue(16'h8000, 16'h8000, 0, 0, 1, 16'h0000, 1, 1);
        finish_op(4);
        issue(16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1);
        finish_op(4);
        repeat (3) @(negedge clk);
        check("hold_sum", 32'(sum), 32'h8000);
        check("hold_ovf", 32'(ovf), 1);
        check("hold_done", 32'(done), 0);
        issue(16'h0001, 16'h0001, 1, 0, 1, 16'h0003, 0, 0);
        @(negedge clk);
        a = 16'h1234; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_op(3);
        @(negedge clk);
        issue(16'hFFFF, 16'hFFFF, 0, 0, 0, 16'h0000, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_sum", 32'(sum), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_cout", 32'(cout), 0);
        err = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) err++;
        end
        check("abort_quiet", err, 0);
        issue(16'h1111, 16'h2222, 0, 0, 1, 16'h3333, 0, 0);
        finish_op(4);
`ifdef CHUNK_ADDER_SUB_EN
        issue(16'h0005, 16'h0007, 0, 1, 1, 16'hFFFE, 0, 0);
        finish_op(4);
        issue(16'h8000, 16'h0001, 0, 1, 1, 16'h7FFF, 1, 1);
        finish_op(4);
`endif
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
